// File: rtl/game_pkg.sv
// Shared types and elaboration-time helpers for the game-flow controller:
// FSM state codes, BCD digit type, integer-to-BCD conversion and saturation value.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_PLAY        = 3'd1,
        S_LOSE        = 3'd2,
        S_WIN         = 3'd3,
        S_SCORE_ADD   = 3'd4,
        S_LEVEL_CHECK = 3'd5,
        S_PAUSE       = 3'd6
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int BCD_MAX_DIGITS = 8;
    localparam int BCD_MAX_W      = 4 * BCD_MAX_DIGITS;

    localparam logic [BCD_MAX_W-1:0] ALL_NINES = {BCD_MAX_DIGITS{4'h9}};

    // Values that do not fit in 'digits' clamp to all nines, matching score saturation.
    function automatic logic [BCD_MAX_W-1:0] to_bcd(input int value, input int digits);
        logic [BCD_MAX_W-1:0] bcd;
        int rem;
        bcd = '0;
        rem = (value < 0) ? 0 : value;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            if (i < digits) begin
                bcd[4*i +: 4] = 4'(rem % 10);
                rem           = rem / 10;
            end
        end
        if (rem != 0) begin
            bcd = '0;
            for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
                if (i < digits) bcd[4*i +: 4] = 4'h9;
            end
        end
        return bcd;
    endfunction

endpackage

// File: rtl/game_flow_controller_bcd_serial_adder.sv
// Digit-serial BCD adder: one digit per cycle, LSB first, with a carry register.
// A carry out of the top digit saturates the result to all nines.
module bcd_serial_adder
    import game_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [4*DIGITS-1:0] addend,
    input  logic [4*DIGITS-1:0] score,
    output logic                done,
    output logic [4*DIGITS-1:0] result
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic          r_busy;
    logic [IW-1:0] r_idx;
    logic          r_carry;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_sum;

    logic [4:0]    w_raw;
    bcd_digit_t    w_digit;
    logic          w_carry_out;
    logic [W+3:0]  w_ext;
    logic [W-1:0]  w_sum_next;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_digit     = '0;
        w_carry_out = 1'b0;
        w_raw       = 5'(r_a[3:0]) + 5'(r_b[3:0]) + 5'(r_carry);
        if (w_raw > 5'd9) begin
            w_digit     = 4'(w_raw - 5'd10);
            w_carry_out = 1'b1;
        end else begin
            w_digit     = w_raw[3:0];
        end
        w_ext      = {w_digit, r_sum};
        w_sum_next = w_ext[W+3:4];
    end

    assign done   = r_busy && (r_idx == IW'(DIGITS - 1));
    assign result = w_carry_out ? ALL_NINES[W-1:0] : w_sum_next;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
        end else if (start) begin
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= score;
            r_b     <= addend;
            r_sum   <= '0;
        end else if (r_busy) begin
            r_a     <= r_a >> 4;
            r_b     <= r_b >> 4;
            r_carry <= w_carry_out;
            r_sum   <= w_sum_next;
            r_idx   <= r_idx + IW'(1);
            if (done) r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/game_flow_controller.sv
// Game-flow controller: shots/targets/level bookkeeping, serial BCD scoring,
// pause, per-frame hit debounce, loss detection and high score. Cheat key behaviour is enabled by GAME_CHEAT_EN.
module game_flow_controller
    import game_pkg::*;
#(
    parameter int NUM_TARGETS    = 3,
    parameter int NUM_SHOTS      = 10,
    parameter int MAX_LEVEL      = 4,
    parameter int SCORE_DIGITS   = 3,
    parameter int HIT_SCORE      = 30,
    parameter int BONUS_PER_SHOT = 1,
    localparam int SW = $clog2(NUM_SHOTS + 1),
    localparam int TW = $clog2(NUM_TARGETS + 1),
    localparam int BW = 4 * SCORE_DIGITS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_of_frame,
    input  logic          draw_req_projectile,
    input  logic          draw_req_border,
    input  logic          draw_req_obstacle,
    input  logic          draw_req_target,
    input  logic          shot_pulse,
    input  logic          start_key,
    input  logic          pause_key,
    input  logic          cheat_key,
    output logic          collision_any,
    output logic          collision_obstacle,
    output logic          collision_target,
    output logic          hit_pulse,
    output logic [BW-1:0] score,
    output logic [BW-1:0] high_score,
    output logic [3:0]    level,
    output logic [2:0]    screen,
    output logic          game_active,
    output logic [SW-1:0] shots_left,
    output logic [TW-1:0] targets_left,
    output logic          new_level_pulse
);

    localparam logic [BCD_MAX_W-1:0] HIT_BCD_FULL = to_bcd(HIT_SCORE, SCORE_DIGITS);
    localparam logic [BW-1:0]        HIT_BCD      = HIT_BCD_FULL[BW-1:0];

    state_t        r_state;
    state_t        w_next_state;
    logic [BW-1:0] r_score;
    logic [BW-1:0] r_high_score;
    logic [3:0]    r_level;
    logic [SW-1:0] r_shots;
    logic [TW-1:0] r_targets;
    logic          r_hit_flag;
    logic          r_pulse_flag;
    logic          r_hit_pulse;
    logic          r_new_level_pulse;
    logic          r_pause_d;
    logic          r_proj_seen;

    logic          w_pause_edge;
    logic          w_cheat_edge;
    logic          w_hit_cand;
    logic          w_pulse_fire;
    logic          w_start_game;
    logic          w_hit_accept;
    logic          w_level_up;
    logic          w_enter_end;
    logic          w_add_done;
    logic [BW-1:0] w_add_result;
    logic [BW-1:0] w_addend;
    logic [BW-1:0] w_bonus_table [NUM_SHOTS+1];

    assign collision_obstacle = draw_req_projectile & draw_req_obstacle;
    assign collision_target   = draw_req_projectile & draw_req_target;
    assign collision_any      = draw_req_projectile &
                                (draw_req_border | draw_req_obstacle | draw_req_target);

    assign w_pause_edge = pause_key & ~r_pause_d;
    // A start_of_frame on the hit cycle opens a new frame, so the hit is let through.
    assign w_hit_cand   = collision_target & (~r_hit_flag | start_of_frame);
    assign w_pulse_fire = collision_any & (~r_pulse_flag | start_of_frame);

`ifdef GAME_CHEAT_EN
    logic r_cheat_d;
    assign w_cheat_edge = cheat_key & ~r_cheat_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_cheat_d <= 1'b0;
        else       r_cheat_d <= cheat_key;
    end
`else
    logic w_unused_cheat;
    assign w_unused_cheat = cheat_key;
    assign w_cheat_edge   = 1'b0;
`endif

    // Clearing-hit addends are precomputed per possible shots_left value.
    for (genvar g = 0; g <= NUM_SHOTS; g++) begin : g_bonus
        localparam logic [BCD_MAX_W-1:0] BONUS_FULL =
            to_bcd(HIT_SCORE + g * BONUS_PER_SHOT, SCORE_DIGITS);
        assign w_bonus_table[g] = BONUS_FULL[BW-1:0];
    end

    assign w_addend = (r_targets == TW'(1)) ? w_bonus_table[r_shots] : HIT_BCD;

    bcd_serial_adder #(
        .DIGITS (SCORE_DIGITS)
    ) u_adder (
        .clk    (clk),
        .reset  (reset),
        .start  (w_hit_accept),
        .addend (w_addend),
        .score  (r_score),
        .done   (w_add_done),
        .result (w_add_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_start_game = 1'b0;
        w_hit_accept = 1'b0;
        w_level_up   = 1'b0;
        unique case (r_state)
            S_IDLE, S_LOSE, S_WIN: begin
                if (start_key) begin
                    w_start_game = 1'b1;
                    w_next_state = S_PLAY;
                end
            end
            S_PLAY: begin
                if (w_pause_edge) begin
                    w_next_state = S_PAUSE;
                end else if (w_hit_cand) begin
                    w_hit_accept = 1'b1;
                    w_next_state = S_SCORE_ADD;
                end else if (w_cheat_edge) begin
                    if (r_level == 4'(MAX_LEVEL)) w_next_state = S_WIN;
                    else                          w_level_up   = 1'b1;
                end else if (start_of_frame && (r_shots == '0) && !r_proj_seen) begin
                    w_next_state = S_LOSE;
                end
            end
            S_SCORE_ADD: begin
                if (w_add_done) w_next_state = S_LEVEL_CHECK;
            end
            S_LEVEL_CHECK: begin
                w_next_state = S_PLAY;
                if (r_targets == '0) begin
                    if (r_level == 4'(MAX_LEVEL)) w_next_state = S_WIN;
                    else                          w_level_up   = 1'b1;
                end
            end
            S_PAUSE: begin
                if (w_pause_edge) w_next_state = S_PLAY;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_enter_end = ((w_next_state == S_LOSE) || (w_next_state == S_WIN)) &&
                         (r_state != S_LOSE) && (r_state != S_WIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_score           <= '0;
            r_high_score      <= '0;
            r_level           <= '0;
            r_shots           <= '0;
            r_targets         <= '0;
            r_new_level_pulse <= 1'b0;
        end else begin
            if (w_start_game) begin
                r_score   <= '0;
                r_level   <= '0;
                r_shots   <= SW'(NUM_SHOTS);
                r_targets <= TW'(NUM_TARGETS);
            end else begin
                if ((r_state == S_PLAY) && shot_pulse && (r_shots != '0))
                    r_shots <= r_shots - SW'(1);
                if (w_hit_accept)
                    r_targets <= r_targets - TW'(1);
                if ((r_state == S_SCORE_ADD) && w_add_done)
                    r_score <= w_add_result;
                if (w_level_up) begin
                    r_level   <= r_level + 4'd1;
                    r_shots   <= SW'(NUM_SHOTS);
                    r_targets <= TW'(NUM_TARGETS);
                end
            end
            if (w_enter_end && (r_score > r_high_score))
                r_high_score <= r_score;
            r_new_level_pulse <= w_level_up;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_flag   <= 1'b0;
            r_pulse_flag <= 1'b0;
            r_hit_pulse  <= 1'b0;
            r_pause_d    <= 1'b0;
            r_proj_seen  <= 1'b0;
        end else begin
            if (w_hit_accept)        r_hit_flag <= 1'b1;
            else if (start_of_frame) r_hit_flag <= 1'b0;

            if (w_pulse_fire)        r_pulse_flag <= 1'b1;
            else if (start_of_frame) r_pulse_flag <= 1'b0;

            r_hit_pulse <= w_pulse_fire;
            r_pause_d   <= pause_key;
            // The start_of_frame cycle already belongs to the new frame.
            r_proj_seen <= start_of_frame ? draw_req_projectile
                                          : (r_proj_seen | draw_req_projectile);
        end
    end

    assign hit_pulse       = r_hit_pulse;
    assign score           = r_score;
    assign high_score      = r_high_score;
    assign level           = r_level;
    assign screen          = r_state;
    assign game_active     = (r_state == S_PLAY) || (r_state == S_SCORE_ADD) ||
                             (r_state == S_LEVEL_CHECK);
    assign shots_left      = r_shots;
    assign targets_left    = r_targets;
    assign new_level_pulse = r_new_level_pulse;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller: collision table plus scoring, debounce,
// saturation (second instance with HIT_SCORE=330), loss, pause, cheat and reset sequences.
module tb_game_flow_controller;

    logic clk = 1'b0;
    logic reset, sof, proj, border, obs, tgt, shot, start, pause, cheat;

    logic        coll_any, coll_obs, coll_tgt, hit_pulse, game_active, new_level_pulse;
    logic [11:0] score, high_score;
    logic [3:0]  level;
    logic [2:0]  screen;
    logic [3:0]  shots_left;
    logic [1:0]  targets_left;

    logic        s_coll_any, s_coll_obs, s_coll_tgt, s_hit_pulse, s_game_active, s_nlp;
    logic [11:0] s_score, s_high_score;
    logic [3:0]  s_level;
    logic [2:0]  s_screen;
    logic [3:0]  s_shots_left;
    logic [1:0]  s_targets_left;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    game_flow_controller u_dut (
        .clk(clk), .reset(reset), .start_of_frame(sof),
        .draw_req_projectile(proj), .draw_req_border(border),
        .draw_req_obstacle(obs), .draw_req_target(tgt),
        .shot_pulse(shot), .start_key(start), .pause_key(pause), .cheat_key(cheat),
        .collision_any(coll_any), .collision_obstacle(coll_obs), .collision_target(coll_tgt),
        .hit_pulse(hit_pulse), .score(score), .high_score(high_score), .level(level),
        .screen(screen), .game_active(game_active), .shots_left(shots_left),
        .targets_left(targets_left), .new_level_pulse(new_level_pulse)
    );

    game_flow_controller #(.HIT_SCORE(330), .BONUS_PER_SHOT(0)) u_dut_sat (
        .clk(clk), .reset(reset), .start_of_frame(sof),
        .draw_req_projectile(proj), .draw_req_border(border),
        .draw_req_obstacle(obs), .draw_req_target(tgt),
        .shot_pulse(shot), .start_key(start), .pause_key(pause), .cheat_key(cheat),
        .collision_any(s_coll_any), .collision_obstacle(s_coll_obs), .collision_target(s_coll_tgt),
        .hit_pulse(s_hit_pulse), .score(s_score), .high_score(s_high_score), .level(s_level),
        .screen(s_screen), .game_active(s_game_active), .shots_left(s_shots_left),
        .targets_left(s_targets_left), .new_level_pulse(s_nlp)
    );

    typedef struct {
        logic proj, border, obs, tgt;
        logic any, c_obs, c_tgt;
    } coll_vec_t;

    coll_vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_hit(input logic [11:0] exp_score, input logic [11:0] exp_sat,
                          input logic exp_nlp, input string tag);
        sof = 1'b1; tick(1); sof = 1'b0;
        proj = 1'b1; tgt = 1'b1; tick(1); proj = 1'b0; tgt = 1'b0;
        check({tag, "_enter_add"}, 32'(screen), 32'd4);
        check({tag, "_hit_pulse"}, 32'(hit_pulse), 32'd1);
        tick(3);
        check({tag, "_level_check"}, 32'(screen), 32'd5);
        check({tag, "_score"}, 32'(score), 32'(exp_score));
        check({tag, "_sat_score"}, 32'(s_score), 32'(exp_sat));
        tick(1);
        check({tag, "_back_play"}, 32'(screen), 32'd1);
        check({tag, "_new_level"}, 32'(new_level_pulse), 32'(exp_nlp));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, entries;
        logic [2:0] prev;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        reset = 1'b1; sof = 0; proj = 0; border = 0; obs = 0; tgt = 0;
        shot = 0; start = 0; pause = 0; cheat = 0;
        tick(2);
        check("rst_screen", 32'(screen), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_high", 32'(high_score), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_shots", 32'(shots_left), 32'd0);
        check("rst_targets", 32'(targets_left), 32'd0);
        check("rst_hit_pulse", 32'(hit_pulse), 32'd0);
        check("rst_nlp", 32'(new_level_pulse), 32'd0);
        check("rst_active", 32'(game_active), 32'd0);
        reset = 1'b0;
        tick(1);

        for (int i = 0; i < 8; i++) begin
            proj = vecs[i].proj; border = vecs[i].border; obs = vecs[i].obs; tgt = vecs[i].tgt;
            #1;
            check($sformatf("coll_any_%0d", i), 32'(coll_any), 32'(vecs[i].any));
            check($sformatf("coll_obs_%0d", i), 32'(coll_obs), 32'(vecs[i].c_obs));
            check($sformatf("coll_tgt_%0d", i), 32'(coll_tgt), 32'(vecs[i].c_tgt));
            tick(1);
        end
        proj = 0; border = 0; obs = 0; tgt = 0;
        check("idle_after_table", 32'(screen), 32'd0);

        start = 1'b1; tick(1); start = 1'b0;
        check("start_screen", 32'(screen), 32'd1);
        check("start_shots", 32'(shots_left), 32'd10);
        check("start_targets", 32'(targets_left), 32'd3);
        check("start_active", 32'(game_active), 32'd1);
        sof = 1'b1; tick(1); sof = 1'b0;

        do_hit(12'h030, 12'h330, 1'b0, "hit1");
        do_hit(12'h060, 12'h660, 1'b0, "hit2");
        do_hit(12'h100, 12'h990, 1'b1, "hit3");
        check("lvl1_level", 32'(level), 32'd1);
        check("lvl1_targets", 32'(targets_left), 32'd3);
        check("lvl1_shots", 32'(shots_left), 32'd10);
        tick(1);
        check("lvl1_nlp_once", 32'(new_level_pulse), 32'd0);
        do_hit(12'h130, 12'h999, 1'b0, "hit4_sat");

        // Target held across two frames: one accepted hit and one hit_pulse per frame.
        sof = 1'b1; tick(1); sof = 1'b0;
        proj = 1'b1; tgt = 1'b1;
        pulses = 0; entries = 0; prev = screen;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            if (hit_pulse) pulses++;
            if (screen == 3'd4 && prev != 3'd4) entries++;
            prev = screen;
        end
        check("holdA_pulses", 32'(pulses), 32'd1);
        check("holdA_hits", 32'(entries), 32'd1);
        check("holdA_targets", 32'(targets_left), 32'd1);
        pulses = 0; entries = 0;
        sof = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            sof = 1'b0;
            if (hit_pulse) pulses++;
            if (screen == 3'd4 && prev != 3'd4) entries++;
            prev = screen;
        end
        proj = 1'b0; tgt = 1'b0;
        check("holdB_pulses", 32'(pulses), 32'd1);
        check("holdB_hits", 32'(entries), 32'd1);
        check("holdB_score", 32'(score), 32'h200);
        check("holdB_sat_score", 32'(s_score), 32'h999);
        check("holdB_level", 32'(level), 32'd2);

        pause = 1'b1; tick(1);
        check("pause_enter", 32'(screen), 32'd6);
        tick(2);
        check("pause_held", 32'(screen), 32'd6);
        pause = 1'b0;
        shot = 1'b1; tick(1); shot = 1'b0;
        check("pause_shots_frozen", 32'(shots_left), 32'd10);
        start = 1'b1; tick(1); start = 1'b0;
        check("pause_start_ignored", 32'(screen), 32'd6);
        check("pause_score_kept", 32'(score), 32'h200);
        pause = 1'b1; tick(1); pause = 1'b0;
        check("pause_exit", 32'(screen), 32'd1);

        shot = 1'b1; tick(3);
        check("shots_after3", 32'(shots_left), 32'd7);
        tick(8); shot = 1'b0;
        check("shots_floor", 32'(shots_left), 32'd0);
        sof = 1'b1; tick(1); sof = 1'b0;
        check("no_loss_proj_seen", 32'(screen), 32'd1);
        sof = 1'b1; tick(1); sof = 1'b0;
        check("loss_screen", 32'(screen), 32'd2);
        check("loss_high", 32'(high_score), 32'h200);
        check("loss_sat_high", 32'(s_high_score), 32'h999);
        check("loss_level_held", 32'(level), 32'd2);
        check("loss_inactive", 32'(game_active), 32'd0);

        start = 1'b1; tick(1); start = 1'b0;
        check("g2_score", 32'(score), 32'd0);
        check("g2_level", 32'(level), 32'd0);
        do_hit(12'h030, 12'h330, 1'b0, "g2_hit");
        shot = 1'b1; tick(10); shot = 1'b0;
        sof = 1'b1; tick(1); sof = 1'b0;
        sof = 1'b1; tick(1); sof = 1'b0;
        check("g2_loss", 32'(screen), 32'd2);
        check("g2_high_kept", 32'(high_score), 32'h200);
        check("g2_sat_high_kept", 32'(s_high_score), 32'h999);

        start = 1'b1; tick(1); start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cheat = 1'b1; tick(1); cheat = 1'b0; tick(1);
`ifdef GAME_CHEAT_EN
            check($sformatf("cheat_level_%0d", k), 32'(level), (k < 5) ? 32'(k) : 32'd4);
            check($sformatf("cheat_screen_%0d", k), 32'(screen), (k < 5) ? 32'd1 : 32'd3);
`else
            check($sformatf("cheat_level_%0d", k), 32'(level), 32'd0);
            check($sformatf("cheat_screen_%0d", k), 32'(screen), 32'd1);
`endif
        end

        start = 1'b1; tick(1); start = 1'b0;
        check("g4_play", 32'(screen), 32'd1);
        sof = 1'b1; tick(1); sof = 1'b0;
        proj = 1'b1; tgt = 1'b1; tick(1); proj = 1'b0; tgt = 1'b0;
        tick(1);
        check("abort_in_add", 32'(screen), 32'd4);
        reset = 1'b1; #1;
        check("abort_screen", 32'(screen), 32'd0);
        check("abort_high", 32'(high_score), 32'd0);
        check("abort_targets", 32'(targets_left), 32'd0);
        tick(2); reset = 1'b0; tick(5);
        check("abort_idle", 32'(screen), 32'd0);
        check("abort_score", 32'(score), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/game_flow_controller.md
# game_flow_controller

Parametrised game-flow controller for the VGA game, sitting between the per-object drawing-request generators and the score/level display, sound and object-reset logic. Counts shots and remaining targets per level and accumulates a saturating multi-digit BCD score through a digit-serial adder. Provides pause, a per-frame hit debounce, frame-based loss detection and a persistent high score.

## Interface
Parameters:
- NUM_TARGETS, 3: targets per level
- NUM_SHOTS, 10: shots per level
- MAX_LEVEL, 4: last level index, levels 0..MAX_LEVEL
- SCORE_DIGITS, 3: BCD digits of score and high score
- HIT_SCORE, 30: decimal points per target hit
- BONUS_PER_SHOT, 1: decimal bonus points per unused shot on level clear

Ports (SW = $clog2(NUM_SHOTS+1), TW = $clog2(NUM_TARGETS+1)):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- start_of_frame  in  1  one-cycle pulse per frame
- draw_req_projectile, draw_req_border, draw_req_obstacle, draw_req_target  in  1 each  pixel drawing requests
- shot_pulse  in  1  one-cycle pulse per launched projectile
- start_key, pause_key, cheat_key  in  1 each  level-sensitive keys
- collision_any, collision_obstacle, collision_target  out  1 each  combinational collisions
- hit_pulse  out  1  at most one pulse per frame on collision_any
- score, high_score  out  4*SCORE_DIGITS  packed BCD, digit 0 in LSBs
- level  out  4  current level
- screen  out  3  FSM state code
- game_active  out  1  high in PLAY, SCORE_ADD, LEVEL_CHECK
- shots_left  out  SW;  targets_left  out  TW
- new_level_pulse  out  1  one cycle on level advance

## Operation
- collision_obstacle = projectile & obstacle; collision_target = projectile & target; collision_any = projectile & (border | obstacle | target).
- States and screen codes: IDLE=0, PLAY=1, LOSE=2, WIN=3, SCORE_ADD=4, LEVEL_CHECK=5, PAUSE=6.
- IDLE/LOSE/WIN: start_key high -> score=0, level=0, shots_left=NUM_SHOTS, targets_left=NUM_TARGETS, go to PLAY. level holds its last value in LOSE/WIN.
- PLAY, priority high to low per cycle:
  - pause_key rising edge -> PAUSE.
  - Accepted target hit -> targets_left-1, load addend, go to SCORE_ADD. A hit is accepted when collision_target=1 and hit_flag=0; acceptance sets hit_flag, and start_of_frame clears it.
  - Cheat (see Configuration).
  - Loss check on start_of_frame: shots_left==0 and no projectile pixel in the frame just ended -> LOSE.
- shot_pulse in PLAY decrements shots_left, saturating at 0; it is ignored in every other state.
- PAUSE: pause_key rising edge -> PLAY. All counters are frozen and start_key is ignored.
- Addend:
  - Normal hit: BCD(HIT_SCORE).
  - Hit with targets_left==1: BCD(HIT_SCORE + shots_left*BONUS_PER_SHOT), computed in binary and then converted to BCD.
- SCORE_ADD: adds one digit per cycle, LSB first, with carry. If the final carry is set, score saturates to all nines. Then go to LEVEL_CHECK.
- LEVEL_CHECK:
  - targets_left==0 and level==MAX_LEVEL -> WIN.
  - targets_left==0 and level<MAX_LEVEL -> level+1, refill shots and targets, new_level_pulse=1, go to PLAY.
  - Otherwise -> PLAY.
- High score: on entry to LOSE or WIN, if score > high_score (compared as an unsigned packed value), then high_score <= score. Only reset clears high_score.
- hit_pulse: on the first cycle collision_any=1 within a frame, pulse for one cycle. The pulse flag is independent of hit_flag.

## Timing
- Reset: state IDLE. All counters, score, high_score, level and flags are 0. hit_pulse and new_level_pulse are 0.
- Collision outputs have zero latency. hit_pulse is registered and asserts one cycle after the qualifying collision.
- Hit to updated score: 1 cycle to enter SCORE_ADD, SCORE_DIGITS cycles of addition, then LEVEL_CHECK for 1 cycle. Total SCORE_DIGITS+2 cycles back to PLAY.
- Key edges use a 1-cycle delayed copy, so a held key acts once.
- A start_of_frame arriving on the same cycle as an accepted hit both clears hit_flag and lets the hit through.
- Reset asserted mid-SCORE_ADD aborts the addition; there is no partial score retention.

## Configuration
- GAME_CHEAT_EN defined: a cheat_key rising edge in PLAY goes to WIN if level==MAX_LEVEL. Otherwise it does level+1, refills shots and targets, and pulses new_level_pulse.
- Undefined: cheat_key is left unused (port retained) and the cheat logic is absent.

## Structure
- Package game_pkg holds:
  - the state enum with the codes above;
  - a BCD digit typedef;
  - an elaboration-time function to_bcd(int, digits);
  - the constant for the all-nines saturation value.
- Sub-module bcd_serial_adder:
  - inputs: start, addend, score;
  - one digit per cycle, carry register, saturation;
  - outputs: done pulse and result.

## Test plan
- Reset, start_key, then 3 target hits in separate frames with 10 shots unused before the last hit. Expect score to read 030, then 060, then 100 (BCD 0x100). level=1 and new_level_pulse asserts once.
- Hold collision_target for 2 frames. Expect exactly 2 accepted hits, and hit_pulse fires once per frame.
- Start with score 0x990 and SCORE_DIGITS=3, then hit. Expect saturation at 0x999.
- Exhaust 10 shots with no projectile pixel drawn in the next frame. Expect screen=2 at that start_of_frame, and high_score updated only if larger.
- Press pause during PLAY and pulse shot_pulse. Expect shots_left unchanged; a second pause press returns to PLAY.
- With GAME_CHEAT_EN, 5 cheat presses from level 0. Expect level reaching 4, then screen=3. Without the macro, level stays 0.
